// File: rtl/alu_seq_pkg.sv
// Shared types and constants for the ALU op sequencer.
//   op_e      : 4-bit ALU operation code presented by instruction decode
//   state_e   : sequencer FSM state
//   alu_fn_e  : function select (the single enable) driven into the ALU
//   FLG_*     : bit positions inside the {N,V,Z,C} status nibble
//   flag_mask : which status bits an op is allowed to update at commit
// Build option: DECIMAL_MODE_EN (see alu_op_sequencer.sv).
package alu_seq_pkg;

  typedef enum logic [3:0] {
    OP_ORA = 4'h0,
    OP_AND = 4'h1,
    OP_EOR = 4'h2,
    OP_ADC = 4'h3,
    OP_SBC = 4'h4,
    OP_CMP = 4'h5,
    OP_ASL = 4'h6,
    OP_LSR = 4'h7,
    OP_ROL = 4'h8,
    OP_ROR = 4'h9,
    OP_INC = 4'hA,
    OP_DEC = 4'hB
  } op_e;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    PASS1 = 2'd1,
    PASS2 = 2'd2,
    DONE  = 2'd3
  } state_e;

  typedef enum logic [2:0] {
    FN_OR  = 3'd0,
    FN_AND = 3'd1,
    FN_EOR = 3'd2,
    FN_SUM = 3'd3,
    FN_SHR = 3'd4
  } alu_fn_e;

  localparam int FLG_N = 3;
  localparam int FLG_V = 2;
  localparam int FLG_Z = 1;
  localparam int FLG_C = 0;

  // Status bits written by each op; bits outside the mask keep their value.
  // Codes C-F are not in op_e and fall through to "update nothing".
  function automatic logic [3:0] flag_mask(input op_e op);
    logic [3:0] m;
    m = 4'b0000;
    case (op)
      OP_ORA, OP_AND, OP_EOR, OP_INC, OP_DEC: m = 4'b1010;
      OP_ADC, OP_SBC:                         m = 4'b1111;
      OP_CMP, OP_ASL, OP_ROL, OP_LSR, OP_ROR: m = 4'b1011;
      default:                                m = 4'b0000;
    endcase
    return m;
  endfunction

endpackage

// File: rtl/alu_op_sequencer_alu.sv
// Combinational 8-bit ALU used by the sequencer for every pass.
// Ports:
//   fn_i    : function select (one enable per pass)
//   a_i     : operand A
//   b_i     : operand B
//   cin_i   : carry-in for FN_SUM
//   y_o     : result byte
//   carry_o : carry out of FN_SUM, bit shifted out for FN_SHR, else 0
//   ovf_o   : signed overflow of FN_SUM, else 0
// N and Z are not produced here; the sequencer derives them from the final byte.
module alu_op_sequencer_alu
  import alu_seq_pkg::*;
(
  input  alu_fn_e    fn_i,
  input  logic [7:0] a_i,
  input  logic [7:0] b_i,
  input  logic       cin_i,
  output logic [7:0] y_o,
  output logic       carry_o,
  output logic       ovf_o
);

  logic [8:0] sum;

  assign sum = {1'b0, a_i} + {1'b0, b_i} + {8'b0, cin_i};

  always_comb begin
    y_o     = 8'h00;
    carry_o = 1'b0;
    ovf_o   = 1'b0;
    case (fn_i)
      FN_OR:  y_o = a_i | b_i;
      FN_AND: y_o = a_i & b_i;
      FN_EOR: y_o = a_i ^ b_i;
      FN_SUM: begin
        y_o     = sum[7:0];
        carry_o = sum[8];
        // Operands of equal sign producing a result of the other sign.
        ovf_o   = (a_i[7] == b_i[7]) && (sum[7] != a_i[7]);
      end
      FN_SHR: begin
        y_o     = {1'b0, a_i[7:1]};
        carry_o = a_i[0];
      end
      default: y_o = 8'h00;
    endcase
  end

endmodule

// File: rtl/alu_op_sequencer.sv
// Multi-cycle controller for the 6502 ALU. Takes one op per request, runs it as
// one or two ALU passes, owns the {N,V,Z,C} status register and returns the
// result over a valid/ready handshake.
// Ports:
//   clk, rst        : clock, synchronous active-high reset
//   op_valid_IN/op_ready_OUT : request handshake (ready only in IDLE)
//   op_code_IN, a_IN, b_IN   : operation and operands
//   decimal_IN      : D flag, only honoured when DECIMAL_MODE_EN is defined
//   flag_wr_IN/flag_data_IN  : external status load, wins over an op commit
//   res_valid_OUT/res_ready_IN : result handshake
//   result_OUT, res_wr_OUT   : result byte, register-write qualifier (0 for CMP)
//   flags_OUT       : {N,V,Z,C}
//   dbg_state_OUT   : current FSM state
// Handshakes: a transfer happens on a rising edge where valid and ready are both
// high; valid, once raised, and its payload stay stable until that transfer.
// Build option: `define DECIMAL_MODE_EN adds a BCD adjust pass to ADC/SBC when
// the latched D flag is set. Without it ADC/SBC are always binary, single pass.
module alu_op_sequencer
  import alu_seq_pkg::*;
#(
  parameter logic [3:0] RESET_FLAGS = 4'b0000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       op_valid_IN,
  output logic       op_ready_OUT,
  input  logic [3:0] op_code_IN,
  input  logic [7:0] a_IN,
  input  logic [7:0] b_IN,
  input  logic       decimal_IN,
  input  logic       flag_wr_IN,
  input  logic [3:0] flag_data_IN,
  output logic       res_valid_OUT,
  input  logic       res_ready_IN,
  output logic [7:0] result_OUT,
  output logic       res_wr_OUT,
  output logic [3:0] flags_OUT,
  output state_e     dbg_state_OUT
);

  state_e     state_q;
  op_e        op_q;
  logic [7:0] a_q, b_q;
  logic       c_q;        // carry flag captured at accept
  logic       wb_q;       // last pass result sits in the pass registers
  logic [7:0] p_res_q;
  logic       p_n_q, p_v_q, p_z_q, p_c_q;
  logic [7:0] result_q;
  logic       res_wr_q, res_valid_q, op_ready_q;
  logic [3:0] flags_q;

  alu_fn_e    alu_fn;
  logic [7:0] alu_a, alu_b, alu_y;
  logic       alu_cin, alu_co, alu_v;

  logic       two_pass;
  logic       commit;
  logic [3:0] mask, cand_flags, commit_flags;

`ifdef DECIMAL_MODE_EN
  logic       d_q;
  logic [4:0] lo_sum, hi_sum, lo_dif, hi_dif;
  logic       lo_adj, hi_adj;
  logic [7:0] dec_adj;
  logic       dec_c;

  // BCD correction worked out from the latched operands: per-nibble decimal
  // carry (ADC) or borrow (SBC) selects 06/60/66, applied to the binary sum.
  always_comb begin
    lo_sum = {1'b0, a_q[3:0]} + {1'b0, b_q[3:0]} + {4'b0, c_q};
    hi_sum = {1'b0, a_q[7:4]} + {1'b0, b_q[7:4]} + {4'b0, (lo_sum > 5'd9)};
    lo_dif = {1'b0, a_q[3:0]} - {1'b0, b_q[3:0]} - {4'b0, ~c_q};
    hi_dif = {1'b0, a_q[7:4]} - {1'b0, b_q[7:4]} - {4'b0, lo_dif[4]};
    if (op_q == OP_SBC) begin
      lo_adj = lo_dif[4];
      hi_adj = hi_dif[4];
      dec_c  = ~hi_dif[4];
    end else begin
      lo_adj = (lo_sum > 5'd9);
      hi_adj = (hi_sum > 5'd9);
      dec_c  = (hi_sum > 5'd9);
    end
    dec_adj = {(hi_adj ? 4'h6 : 4'h0), (lo_adj ? 4'h6 : 4'h0)};
  end

  assign two_pass = (op_q == OP_ROR) ||
                    (d_q && ((op_q == OP_ADC) || (op_q == OP_SBC)));
`else
  logic unused_decimal;
  assign unused_decimal = decimal_IN;
  assign two_pass       = (op_q == OP_ROR);
`endif

  // Pass decoder: ALU enable, operands and carry-in from state and latched op.
  always_comb begin
    alu_fn  = FN_OR;
    alu_a   = a_q;
    alu_b   = b_q;
    alu_cin = 1'b0;
    if (state_q == PASS2) begin
      alu_a = p_res_q;
      if (op_q == OP_ROR) begin
        alu_fn = FN_OR;
        alu_b  = {c_q, 7'b0};
      end else begin
`ifdef DECIMAL_MODE_EN
        alu_fn  = FN_SUM;
        alu_b   = (op_q == OP_SBC) ? ~dec_adj : dec_adj;
        alu_cin = (op_q == OP_SBC);
`else
        alu_fn = FN_OR;
        alu_b  = 8'h00;
`endif
      end
    end else begin
      case (op_q)
        OP_ORA: alu_fn = FN_OR;
        OP_AND: alu_fn = FN_AND;
        OP_EOR: alu_fn = FN_EOR;
        OP_ADC: begin alu_fn = FN_SUM; alu_cin = c_q; end
        OP_SBC: begin alu_fn = FN_SUM; alu_b = ~b_q; alu_cin = c_q; end
        OP_CMP: begin alu_fn = FN_SUM; alu_b = ~b_q; alu_cin = 1'b1; end
        OP_ASL: begin alu_fn = FN_SUM; alu_b = a_q; end
        OP_ROL: begin alu_fn = FN_SUM; alu_b = a_q; alu_cin = c_q; end
        OP_LSR, OP_ROR: alu_fn = FN_SHR;
        OP_INC: begin alu_fn = FN_SUM; alu_b = 8'h00; alu_cin = 1'b1; end
        OP_DEC: begin alu_fn = FN_SUM; alu_b = 8'hFF; end
        // Unused codes pass A straight through.
        default: begin alu_fn = FN_OR; alu_b = 8'h00; end
      endcase
    end
  end

  alu_op_sequencer_alu u_alu (
    .fn_i    (alu_fn),
    .a_i     (alu_a),
    .b_i     (alu_b),
    .cin_i   (alu_cin),
    .y_o     (alu_y),
    .carry_o (alu_co),
    .ovf_o   (alu_v)
  );

  assign commit       = ((state_q == PASS1) || (state_q == PASS2)) && wb_q;
  assign mask         = flag_mask(op_q);
  assign cand_flags   = {p_n_q, p_v_q, p_z_q, p_c_q};
  assign commit_flags = (flags_q & ~mask) | (cand_flags & mask);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      op_q        <= OP_ORA;
      a_q         <= 8'h00;
      b_q         <= 8'h00;
      c_q         <= 1'b0;
      wb_q        <= 1'b0;
      p_res_q     <= 8'h00;
      p_n_q       <= 1'b0;
      p_v_q       <= 1'b0;
      p_z_q       <= 1'b0;
      p_c_q       <= 1'b0;
      result_q    <= 8'h00;
      res_wr_q    <= 1'b0;
      res_valid_q <= 1'b0;
      op_ready_q  <= 1'b1;
      flags_q     <= RESET_FLAGS;
`ifdef DECIMAL_MODE_EN
      d_q         <= 1'b0;
`endif
    end else begin
      case (state_q)
        IDLE: begin
          if (op_valid_IN) begin
            op_q       <= op_e'(op_code_IN);
            a_q        <= a_IN;
            b_q        <= b_IN;
            c_q        <= flags_q[FLG_C];
`ifdef DECIMAL_MODE_EN
            d_q        <= decimal_IN;
`endif
            wb_q       <= 1'b0;
            op_ready_q <= 1'b0;
            state_q    <= PASS1;
          end
        end
        PASS1: begin
          if (!wb_q) begin
            p_res_q <= alu_y;
            p_n_q   <= alu_y[7];
            p_z_q   <= (alu_y == 8'h00);
            p_v_q   <= alu_v;
            p_c_q   <= ((op_q == OP_LSR) || (op_q == OP_ROR)) ? a_q[0] : alu_co;
            if (two_pass) state_q <= PASS2;
            else          wb_q    <= 1'b1;
          end
        end
        PASS2: begin
          if (!wb_q) begin
            p_res_q <= alu_y;
            if (op_q == OP_ROR) begin
              p_n_q <= alu_y[7];
              p_z_q <= (alu_y == 8'h00);
            end
`ifdef DECIMAL_MODE_EN
            else begin
              // N, V, Z stay from the binary pass; only C is decimal.
              p_c_q <= dec_c;
            end
`endif
            wb_q <= 1'b1;
          end
        end
        DONE: begin
          if (res_ready_IN) begin
            res_valid_q <= 1'b0;
            op_ready_q  <= 1'b1;
            state_q     <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase

      if (commit) begin
        result_q    <= p_res_q;
        res_wr_q    <= (op_q != OP_CMP);
        res_valid_q <= 1'b1;
        wb_q        <= 1'b0;
        state_q     <= DONE;
      end

      if (flag_wr_IN)  flags_q <= flag_data_IN;
      else if (commit) flags_q <= commit_flags;
    end
  end

  assign op_ready_OUT  = op_ready_q;
  assign res_valid_OUT = res_valid_q;
  assign result_OUT    = result_q;
  assign res_wr_OUT    = res_wr_q;
  assign flags_OUT     = flags_q;
  assign dbg_state_OUT = state_q;

endmodule

// File: tb/tb_alu_op_sequencer.sv
module tb_alu_op_sequencer;
  import alu_seq_pkg::*;

  logic       clk = 1'b0;
  logic       rst;
  logic       op_valid, op_ready;
  logic [3:0] op_code;
  logic [7:0] a, b;
  logic       dec;
  logic       flag_wr;
  logic [3:0] flag_data;
  logic       res_valid, res_ready;
  logic [7:0] result;
  logic       res_wr;
  logic [3:0] flags;
  state_e     dbg_state;

  int n_cmp  = 0;
  int n_fail = 0;

  alu_op_sequencer #(.RESET_FLAGS(4'b0000)) dut (
    .clk           (clk),
    .rst           (rst),
    .op_valid_IN   (op_valid),
    .op_ready_OUT  (op_ready),
    .op_code_IN    (op_code),
    .a_IN          (a),
    .b_IN          (b),
    .decimal_IN    (dec),
    .flag_wr_IN    (flag_wr),
    .flag_data_IN  (flag_data),
    .res_valid_OUT (res_valid),
    .res_ready_IN  (res_ready),
    .result_OUT    (result),
    .res_wr_OUT    (res_wr),
    .flags_OUT     (flags),
    .dbg_state_OUT (dbg_state)
  );

  // clock / reset
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // driver tasks
  task automatic wait_clk();
    @(posedge clk);
    #1;
  endtask

  task automatic set_flags(input logic [3:0] f);
    flag_wr   = 1'b1;
    flag_data = f;
    wait_clk();
    flag_wr   = 1'b0;
  endtask

  // Issue one op, measure edges from accept to res_valid, capture outputs, release.
  task automatic run_op(input logic [3:0] op, input logic [7:0] ia, input logic [7:0] ib,
                        input logic d, output int lat, output logic [7:0] res,
                        output logic wr, output logic [3:0] flg);
    op_valid = 1'b1;
    op_code  = op;
    a        = ia;
    b        = ib;
    dec      = d;
    wait_clk();
    op_valid = 1'b0;
    lat = 0;
    while (!res_valid && lat < 20) begin
      wait_clk();
      lat++;
    end
    res = result;
    wr  = res_wr;
    flg = flags;
    res_ready = 1'b1;
    wait_clk();
    res_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    wait_clk();
    wait_clk();
    rst = 1'b0;
    n_cmp++; if (op_ready !== 1'b1) begin n_fail++; $display("FAIL reset_op_ready: got %b want 1", op_ready); end
    n_cmp++; if (res_valid !== 1'b0) begin n_fail++; $display("FAIL reset_res_valid: got %b want 0", res_valid); end
    n_cmp++; if (result !== 8'h00) begin n_fail++; $display("FAIL reset_result: got %h want 00", result); end
    n_cmp++; if (res_wr !== 1'b0) begin n_fail++; $display("FAIL reset_res_wr: got %b want 0", res_wr); end
    n_cmp++; if (flags !== 4'b0000) begin n_fail++; $display("FAIL reset_flags: got %b want 0000", flags); end
  endtask

  task automatic test_adc();
    int lat; logic [7:0] r; logic w; logic [3:0] f;
    set_flags(4'b0000);
    run_op(4'h3, 8'h50, 8'h50, 1'b0, lat, r, w, f);
    n_cmp++; if (r !== 8'hA0) begin n_fail++; $display("FAIL adc_result: got %h want a0", r); end
    n_cmp++; if (f !== 4'b1100) begin n_fail++; $display("FAIL adc_flags: got %b want 1100", f); end
    n_cmp++; if (lat !== 2) begin n_fail++; $display("FAIL adc_latency: got %0d want 2", lat); end
    n_cmp++; if (w !== 1'b1) begin n_fail++; $display("FAIL adc_res_wr: got %b want 1", w); end
  endtask

  task automatic test_sbc_cmp();
    int lat; logic [7:0] r; logic w; logic [3:0] f;
    set_flags(4'b0001);
    run_op(4'h4, 8'h00, 8'h01, 1'b0, lat, r, w, f);
    n_cmp++; if (r !== 8'hFF) begin n_fail++; $display("FAIL sbc_result: got %h want ff", r); end
    n_cmp++; if (f !== 4'b1000) begin n_fail++; $display("FAIL sbc_flags: got %b want 1000", f); end
    run_op(4'h5, 8'h40, 8'h40, 1'b0, lat, r, w, f);
    n_cmp++; if (f !== 4'b0011) begin n_fail++; $display("FAIL cmp_flags: got %b want 0011", f); end
    n_cmp++; if (w !== 1'b0) begin n_fail++; $display("FAIL cmp_res_wr: got %b want 0", w); end
    n_cmp++; if (lat !== 2) begin n_fail++; $display("FAIL cmp_latency: got %0d want 2", lat); end
  endtask

  task automatic test_shift();
    int lat; logic [7:0] r; logic w; logic [3:0] f;
    set_flags(4'b0001);
    run_op(4'h9, 8'h01, 8'h00, 1'b0, lat, r, w, f);
    n_cmp++; if (r !== 8'h80) begin n_fail++; $display("FAIL ror_result: got %h want 80", r); end
    n_cmp++; if (f !== 4'b1001) begin n_fail++; $display("FAIL ror_flags: got %b want 1001", f); end
    n_cmp++; if (lat !== 3) begin n_fail++; $display("FAIL ror_latency: got %0d want 3", lat); end
    run_op(4'h7, 8'h01, 8'h00, 1'b0, lat, r, w, f);
    n_cmp++; if (r !== 8'h00) begin n_fail++; $display("FAIL lsr_result: got %h want 00", r); end
    n_cmp++; if (f !== 4'b0011) begin n_fail++; $display("FAIL lsr_flags: got %b want 0011", f); end
    n_cmp++; if (lat !== 2) begin n_fail++; $display("FAIL lsr_latency: got %0d want 2", lat); end
    // ASL 81 -> 02, carry out 1, N/Z clear
    run_op(4'h6, 8'h81, 8'h00, 1'b0, lat, r, w, f);
    n_cmp++; if (r !== 8'h02) begin n_fail++; $display("FAIL asl_result: got %h want 02", r); end
    n_cmp++; if (f !== 4'b0001) begin n_fail++; $display("FAIL asl_flags: got %b want 0001", f); end
    // ROL 80 with C=1 -> 01, carry out 1
    run_op(4'h8, 8'h80, 8'h00, 1'b0, lat, r, w, f);
    n_cmp++; if (r !== 8'h01) begin n_fail++; $display("FAIL rol_result: got %h want 01", r); end
    n_cmp++; if (f !== 4'b0001) begin n_fail++; $display("FAIL rol_flags: got %b want 0001", f); end
  endtask

  task automatic test_inc_dec_misc();
    int lat; logic [7:0] r; logic w; logic [3:0] f;
    set_flags(4'b0000);
    run_op(4'hA, 8'hFF, 8'h00, 1'b0, lat, r, w, f);
    n_cmp++; if (r !== 8'h00) begin n_fail++; $display("FAIL inc_result: got %h want 00", r); end
    n_cmp++; if (f !== 4'b0010) begin n_fail++; $display("FAIL inc_flags: got %b want 0010", f); end
    // DEC 01 -> 00 with C=1, V=1 preset: both held
    set_flags(4'b0101);
    run_op(4'hB, 8'h01, 8'h00, 1'b0, lat, r, w, f);
    n_cmp++; if (r !== 8'h00) begin n_fail++; $display("FAIL dec_result: got %h want 00", r); end
    n_cmp++; if (f !== 4'b0111) begin n_fail++; $display("FAIL dec_flags: got %b want 0111", f); end
    // EOR FF^0F -> F0, N set, Z clear, V/C held
    run_op(4'h2, 8'hFF, 8'h0F, 1'b0, lat, r, w, f);
    n_cmp++; if (r !== 8'hF0) begin n_fail++; $display("FAIL eor_result: got %h want f0", r); end
    n_cmp++; if (f !== 4'b1101) begin n_fail++; $display("FAIL eor_flags: got %b want 1101", f); end
    // Unused code D: result = a, flags untouched, written back
    run_op(4'hD, 8'h00, 8'h55, 1'b0, lat, r, w, f);
    n_cmp++; if (r !== 8'h00) begin n_fail++; $display("FAIL unused_result: got %h want 00", r); end
    n_cmp++; if (f !== 4'b1101) begin n_fail++; $display("FAIL unused_flags: got %b want 1101", f); end
    n_cmp++; if (w !== 1'b1) begin n_fail++; $display("FAIL unused_res_wr: got %b want 1", w); end
  endtask

  task automatic test_flag_wr_priority();
    set_flags(4'b0000);
    op_valid = 1'b1; op_code = 4'h1; a = 8'hF0; b = 8'h0F; dec = 1'b0;
    wait_clk();                 // accept
    op_valid = 1'b0;
    wait_clk();                 // PASS1 registered
    flag_wr = 1'b1; flag_data = 4'b0001;
    wait_clk();                 // commit edge, external load wins
    flag_wr = 1'b0;
    n_cmp++; if (res_valid !== 1'b1) begin n_fail++; $display("FAIL and_commit_valid: got %b want 1", res_valid); end
    n_cmp++; if (result !== 8'h00) begin n_fail++; $display("FAIL and_result: got %h want 00", result); end
    n_cmp++; if (flags !== 4'b0001) begin n_fail++; $display("FAIL flag_wr_priority: got %b want 0001", flags); end
    res_ready = 1'b1;
    wait_clk();
    res_ready = 1'b0;
  endtask

  task automatic test_back_to_back();
    int k;
    op_valid = 1'b1; op_code = 4'h2; a = 8'h3C; b = 8'hFF; dec = 1'b0;
    wait_clk();
    op_valid = 1'b0;
    k = 0;
    while (!res_valid && k < 20) begin wait_clk(); k++; end
    n_cmp++; if (res_valid !== 1'b1) begin n_fail++; $display("FAIL bp_valid_timeout: got %b want 1", res_valid); end
    // hold off the consumer and offer a competing request
    op_valid = 1'b1; op_code = 4'h0; a = 8'h11; b = 8'h22;
    for (int i = 0; i < 3; i++) begin
      wait_clk();
      n_cmp++; if (result !== 8'hC3) begin n_fail++; $display("FAIL bp_result_%0d: got %h want c3", i, result); end
      n_cmp++; if (res_valid !== 1'b1) begin n_fail++; $display("FAIL bp_valid_%0d: got %b want 1", i, res_valid); end
      n_cmp++; if (op_ready !== 1'b0) begin n_fail++; $display("FAIL bp_op_ready_%0d: got %b want 0", i, op_ready); end
    end
    op_valid = 1'b0;
    res_ready = 1'b1;
    wait_clk();
    res_ready = 1'b0;
    n_cmp++; if (res_valid !== 1'b0) begin n_fail++; $display("FAIL bp_release_valid: got %b want 0", res_valid); end
    n_cmp++; if (op_ready !== 1'b1) begin n_fail++; $display("FAIL bp_release_ready: got %b want 1", op_ready); end
    wait_clk();
    wait_clk();
    n_cmp++; if (dbg_state !== IDLE) begin n_fail++; $display("FAIL bp_ignored_op: state %0d want IDLE", dbg_state); end
  endtask

  task automatic test_reset_mid_op();
    set_flags(4'b0101);
    op_valid = 1'b1; op_code = 4'h9; a = 8'h01; b = 8'h00; dec = 1'b0;
    wait_clk();                 // accept -> PASS1
    op_valid = 1'b0;
    wait_clk();                 // -> PASS2
    n_cmp++; if (dbg_state !== PASS2) begin n_fail++; $display("FAIL mid_in_pass2: state %0d want PASS2", dbg_state); end
    rst = 1'b1;
    wait_clk();
    rst = 1'b0;
    n_cmp++; if (dbg_state !== IDLE) begin n_fail++; $display("FAIL mid_rst_state: state %0d want IDLE", dbg_state); end
    n_cmp++; if (flags !== 4'b0000) begin n_fail++; $display("FAIL mid_rst_flags: got %b want 0000", flags); end
    n_cmp++; if (op_ready !== 1'b1) begin n_fail++; $display("FAIL mid_rst_ready: got %b want 1", op_ready); end
    wait_clk();
    wait_clk();
    n_cmp++; if (res_valid !== 1'b0) begin n_fail++; $display("FAIL mid_rst_no_result: got %b want 0", res_valid); end
  endtask

  task automatic test_decimal();
    int lat; logic [7:0] r; logic w; logic [3:0] f;
    set_flags(4'b0000);
    run_op(4'h3, 8'h19, 8'h28, 1'b1, lat, r, w, f);
`ifdef DECIMAL_MODE_EN
    n_cmp++; if (r !== 8'h47) begin n_fail++; $display("FAIL dadc_result: got %h want 47", r); end
    n_cmp++; if (f !== 4'b0000) begin n_fail++; $display("FAIL dadc_flags: got %b want 0000", f); end
    n_cmp++; if (lat !== 3) begin n_fail++; $display("FAIL dadc_latency: got %0d want 3", lat); end
    set_flags(4'b0001);
    run_op(4'h4, 8'h00, 8'h01, 1'b1, lat, r, w, f);
    n_cmp++; if (r !== 8'h99) begin n_fail++; $display("FAIL dsbc_result: got %h want 99", r); end
    n_cmp++; if (f !== 4'b1000) begin n_fail++; $display("FAIL dsbc_flags: got %b want 1000", f); end
`else
    n_cmp++; if (r !== 8'h41) begin n_fail++; $display("FAIL badc_result: got %h want 41", r); end
    n_cmp++; if (f !== 4'b0000) begin n_fail++; $display("FAIL badc_flags: got %b want 0000", f); end
    n_cmp++; if (lat !== 2) begin n_fail++; $display("FAIL badc_latency: got %0d want 2", lat); end
`endif
  endtask

  initial begin
    rst = 1'b1; op_valid = 1'b0; op_code = 4'h0; a = 8'h00; b = 8'h00;
    dec = 1'b0; flag_wr = 1'b0; flag_data = 4'h0; res_ready = 1'b0;
    test_reset();
    test_adc();
    test_sbc_cmp();
    test_shift();
    test_inc_dec_misc();
    test_flag_wr_priority();
    test_back_to_back();
    test_reset_mid_op();
    test_decimal();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
